// File: rtl/mem_stage_if.sv
// mem_stage_if: data-memory bus between the memory stage and data memory.
// master (mem_stage): drives dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata;
//   samples dmem_ready, dmem_rdata.
// slave (memory): the mirror image.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_ready, dmem_rdata);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_ready, dmem_rdata);
endinterface

// File: rtl/mem_stage.sv
// mem_stage: pipeline memory stage; issues loads/stores on the dmem bus and registers write-back.
// Ports:
//   clk, reset (async, active-low)
//   rd_write_enable_in, rd_write_addr_in, res_src_in, mem_write_enable_in, mem_width_in,
//   exec_result_in, mem_write_data_in, next_pc_in  : instruction from execute
//   dmem                                            : data-memory bus (master)
//   stall_out, mem_forward                          : combinational hazard/forwarding outputs
//   rd_write_enable_out, rd_write_addr_out, wb_data_out, misaligned_out : registered write-back
module mem_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd_write_enable_in,
  input  logic [4:0]  rd_write_addr_in,
  input  logic [1:0]  res_src_in,
  input  logic        mem_write_enable_in,
  input  logic [2:0]  mem_width_in,
  input  logic [31:0] exec_result_in,
  input  logic [31:0] mem_write_data_in,
  input  logic [31:0] next_pc_in,
  mem_stage_if.master dmem,
  output logic        stall_out,
  output logic [31:0] mem_forward,
  output logic        rd_write_enable_out,
  output logic [4:0]  rd_write_addr_out,
  output logic [31:0] wb_data_out,
  output logic        misaligned_out
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state_q, state_d;
  logic        is_store, is_load, mem_op, bad_align, mis;
  logic [31:0] sh_rdata, ld_data, wb_sel;
  logic        rwe_q, rwe_d, mis_q, mis_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] wb_q, wb_d;
  assign is_store = mem_write_enable_in;
  assign is_load = ~is_store & (res_src_in == 2'b01);
  assign mem_op = is_store | is_load;
  // Widths 011/110/111 are undefined encodings and are flagged as misaligned.
  always_comb begin
    bad_align = (mem_width_in inside {3'b001, 3'b101}) ? exec_result_in[0] :
                (mem_width_in == 3'b010) ? |exec_result_in[1:0] :
                !(mem_width_in inside {3'b000, 3'b100});
    mis = mem_op & bad_align;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb
    state_d = (state_q == IDLE) ? ((dmem.dmem_req & ~dmem.dmem_ready) ? BUSY : IDLE)
                                : (dmem.dmem_ready ? IDLE : BUSY);
  // Gating with reset drops the request immediately when reset hits mid-transaction.
  always_comb begin
    dmem.dmem_req = reset & ((state_q == BUSY) | (mem_op & ~bad_align));
    stall_out = dmem.dmem_req & ~dmem.dmem_ready;
  end
  always_comb begin
    dmem.dmem_we = is_store;
    dmem.dmem_addr = {exec_result_in[31:2], 2'b00};
    dmem.dmem_be = !is_store ? 4'b1111 :
                   (mem_width_in[1:0] == 2'b00) ? 4'b0001 << exec_result_in[1:0] :
                   (mem_width_in[1:0] == 2'b01) ? (exec_result_in[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    dmem.dmem_wdata = (mem_width_in[1:0] == 2'b00) ? {4{mem_write_data_in[7:0]}} :
                      (mem_width_in[1:0] == 2'b01) ? {2{mem_write_data_in[15:0]}} : mem_write_data_in;
  end
  // Shift the addressed byte/half down to bit 0, then extend; width[2] selects zero-extension.
  always_comb begin
    sh_rdata = dmem.dmem_rdata >> {exec_result_in[1:0], 3'b000};
    ld_data = (mem_width_in[1:0] == 2'b00) ? {{24{~mem_width_in[2] & sh_rdata[7]}}, sh_rdata[7:0]} :
              (mem_width_in[1:0] == 2'b01) ? {{16{~mem_width_in[2] & sh_rdata[15]}}, sh_rdata[15:0]} :
              dmem.dmem_rdata;
    wb_sel = (res_src_in == 2'b01) ? ld_data : (res_src_in == 2'b10) ? next_pc_in : exec_result_in;
  end
  always_comb begin
    rwe_d = ~stall_out & rd_write_enable_in & ~is_store & ~mis & |rd_write_addr_in;
    mis_d = mis;
    rd_d = rd_write_addr_in;
    wb_d = wb_sel;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      rwe_q <= 1'b0;
      mis_q <= 1'b0;
      rd_q <= '0;
      wb_q <= '0;
    end else begin
      rwe_q <= rwe_d;
      mis_q <= mis_d;
      rd_q <= rd_d;
      wb_q <= wb_d;
    end
  assign mem_forward = exec_result_in;
  assign rd_write_enable_out = rwe_q;
  assign rd_write_addr_out = rd_q;
  assign wb_data_out = wb_q;
  assign misaligned_out = mis_q;
endmodule
